// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key schedule: one 32-bit schedule word per clock,
// streamed out as 128-bit round keys over a valid/ready handshake.
module aes_key_schedule_seq #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] cipher_key,
  output logic                    busy,
  output logic                    err,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [3:0]              rk_index,
  output logic [127:0]            rk_data,
  output logic                    rk_last
);

  localparam int MAX_WORDS = MAX_KEY_BITS / 32;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
  state_t state, state_next;

  logic [1:0]  klen;
  logic [31:0] hist [8];     // hist[k] = w[i-1-k]; preloaded so the key drains out first
  logic [5:0]  widx;
  logic [2:0]  nk_cnt;       // i mod Nk
  logic        past_key;     // i >= Nk
  logic [7:0]  rc;
  logic [95:0] asm_buf;
  logic [3:0]  round_cnt;

  logic [3:0]  start_nk;
  logic        start_ok;
  logic [31:0] key_word [8];
  logic [31:0] preload [8];
  logic [2:0]  old_sel;
  logic [3:0]  nr;
  logic [5:0]  last_widx;
  logic [31:0] prev, old, sub_in, sub_out, w_new;
  logic        gen_en, xfer;

  always_comb begin
    start_nk = 4'd8;
    case (key_len)
      2'd0:    start_nk = 4'd4;
      2'd1:    start_nk = 4'd6;
      default: start_nk = 4'd8;
    endcase
    start_ok = (key_len != 2'd3) && (32 * int'(start_nk) <= MAX_KEY_BITS);
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_key
    if (gi < MAX_WORDS) begin : g_used
      assign key_word[gi] = cipher_key[MAX_KEY_BITS-1-32*gi -: 32];
    end else begin : g_unused
      assign key_word[gi] = 32'h0;
    end
    assign preload[gi] = (gi < int'(start_nk)) ?
                         key_word[3'(start_nk - 4'd1 - 4'(gi))] : 32'h0;
  end

  always_comb begin
    old_sel   = 3'd7;
    nr        = 4'd14;
    last_widx = 6'd59;
    case (klen)
      2'd0: begin old_sel = 3'd3; nr = 4'd10; last_widx = 6'd43; end
      2'd1: begin old_sel = 3'd5; nr = 4'd12; last_widx = 6'd51; end
      default: ;
    endcase
  end

  assign prev   = hist[0];
  assign old    = hist[old_sel];
  assign sub_in = (nk_cnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub_out[8*gi +: 8] = sbox(sub_in[8*gi +: 8]);
  end

  always_comb begin
    w_new = old ^ prev;
    if (!past_key)
      w_new = old;
    else if (nk_cnt == 3'd0)
      w_new = old ^ sub_out ^ {rc, 24'h0};
    else if (klen == 2'd2 && nk_cnt == 3'd4)
      w_new = old ^ sub_out;
  end

  // The group-completing word waits until the output register can take it.
  assign gen_en = (state == GEN) && !(widx[1:0] == 2'd3 && rk_valid && !rk_ready);
  assign xfer   = gen_en && (widx[1:0] == 2'd3);
  assign busy   = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && start_ok) state_next = GEN;
      GEN:     if (gen_en && widx == last_widx) state_next = DRAIN;
      DRAIN:   if (rk_valid && rk_ready && rk_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      klen      <= 2'd0;
      widx      <= 6'd0;
      nk_cnt    <= 3'd0;
      past_key  <= 1'b0;
      rc        <= 8'h0;
      asm_buf   <= 96'h0;
      round_cnt <= 4'd0;
      err       <= 1'b0;
      rk_valid  <= 1'b0;
      rk_index  <= 4'd0;
      rk_data   <= 128'h0;
      rk_last   <= 1'b0;
      for (int k = 0; k < 8; k++) hist[k] <= 32'h0;
    end else begin
      err <= (state == IDLE) && start && !start_ok;
      if (state == IDLE && start && start_ok) begin
        klen      <= key_len;
        widx      <= 6'd0;
        nk_cnt    <= 3'd0;
        past_key  <= 1'b0;
        rc        <= 8'h01;
        round_cnt <= 4'd0;
        for (int k = 0; k < 8; k++) hist[k] <= preload[k];
      end else if (gen_en) begin
        widx <= widx + 6'd1;
        hist[0] <= w_new;
        for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
        if (nk_cnt == old_sel) begin
          nk_cnt   <= 3'd0;
          past_key <= 1'b1;
        end else begin
          nk_cnt <= nk_cnt + 3'd1;
        end
        if (past_key && nk_cnt == 3'd0)
          rc <= {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        case (widx[1:0])
          2'd0:    asm_buf[95:64] <= w_new;
          2'd1:    asm_buf[63:32] <= w_new;
          2'd2:    asm_buf[31:0]  <= w_new;
          default: ;
        endcase
      end

      if (xfer) begin
        rk_valid  <= 1'b1;
        rk_data   <= {asm_buf, w_new};
        rk_index  <= round_cnt;
        rk_last   <= (round_cnt == nr);
        round_cnt <= round_cnt + 4'd1;
      end else if (rk_valid && rk_ready) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end
    end
  end

endmodule
